mem_arb: RTL and testbench
==========================

# mem_arb

Single-port memory arbiter for the SISC datapath. Shares one synchronous-read memory between the instruction-fetch port (`if_*`) and the load/store port (`ls_*`, driven by LOD/STR/SWP sequencing). The arbiter accepts one transaction at a time, drives the memory, and returns read data or a write acknowledge to the winning requester. It sits between the control FSM/PC logic and the memory model.

## Interface
- `ADDR_W`, 16, memory address width
- `DATA_W`, 32, memory data width
- `MEM_LAT`, 1, memory read latency in cycles after `mem_en` (legal range 1–7)

- `clk` input 1 system clock, rising edge
- `rst_f` input 1 reset; one clock; reset is asynchronous and active-low
- `if_req` input 1 fetch request, level, held until `if_valid` is sampled
- `if_addr` input ADDR_W fetch address
- `if_gnt` output 1 one-cycle pulse: fetch transaction issued to memory
- `if_valid` output 1 one-cycle pulse: `if_rdata` valid
- `if_rdata` output DATA_W fetched word
- `ls_req` input 1 load/store request, level, held until `ls_valid` is sampled
- `ls_we` input 1 1 = store, 0 = load
- `ls_addr` input ADDR_W load/store address
- `ls_wdata` input DATA_W store data
- `ls_gnt` output 1 one-cycle pulse: load/store issued to memory
- `ls_valid` output 1 one-cycle pulse: load data valid / store complete
- `ls_rdata` output DATA_W loaded word; 0 on store completion
- `mem_en` output 1 memory access strobe, one cycle per transaction
- `mem_we` output 1 memory write enable; only ever high together with `mem_en`
- `mem_addr` output ADDR_W memory address
- `mem_wdata` output DATA_W memory write data
- `mem_rdata` input DATA_W memory read data, valid `MEM_LAT` cycles after `mem_en`
- `busy` output 1 high in every state except IDLE

## Operation
- States: IDLE, GRANT, WAIT, RESP. All outputs are registered.
- IDLE: if any request is high, latch the winner, its address, `we`, and `wdata`, then go to GRANT. With no request, stay in IDLE.
- Arbitration when both requests are high in IDLE: `ls` wins (default build). A single request always wins.
- GRANT, one cycle: `mem_en`=1. `mem_addr`, `mem_we`, and `mem_wdata` come from the latches. The winner's `gnt` is 1. Next state is WAIT.
- WAIT: a down-counter loaded with `MEM_LAT` in GRANT decrements each cycle. At the edge where the counter reaches 0, capture `mem_rdata` (or 0 for a store) and go to RESP.
- RESP, one cycle: the winner's `valid`=1 and its `rdata` holds the captured word. Next state is IDLE.
- `rdata` holds its value until the next RESP for that port.
- Requests that arrive while `busy`=1 wait; they are arbitrated in the next IDLE cycle.
- Requester rule: drop `req` at the edge where `valid`=1 is sampled. `req` still high in the following IDLE cycle is a new transaction. Address and data need only be stable in the IDLE cycle in which the request is accepted.
- Memory inputs are not sampled outside the capture edge.

## Timing
- Request first seen high in IDLE at cycle 0:
  - GRANT and `mem_en` in cycle 1
  - `mem_rdata` sampled at the end of cycle 1+`MEM_LAT`
  - `valid` in cycle 2+`MEM_LAT`
  - next IDLE in cycle 3+`MEM_LAT`
- Back-to-back throughput: one transaction per `MEM_LAT`+3 cycles.
- Reset values: state IDLE, all `gnt`/`valid`/`mem_en`/`mem_we`/`busy` 0, all `rdata`/`mem_addr`/`mem_wdata` 0, counter 0, `last_winner` = ls.
- Reset asserted mid-transaction: outputs go to reset values immediately (asynchronously). The in-flight transaction is dropped and no `valid` is issued. After `rst_f` rises, requesters must re-issue.
- Simultaneous `if_req` and `ls_req` arriving in the RESP cycle: both are arbitrated in the next IDLE cycle.
- `gnt` and `valid` of the two ports are never high in the same cycle.

## Configuration
- `MEM_ARB_FAIR_EN` defined: a `last_winner` register is updated in GRANT. On a tie in IDLE, the port that did not win last time is granted, so ties alternate. The reset value ls means the first tie goes to `if`.
- `MEM_ARB_FAIR_EN` undefined: fixed priority, `ls` always wins ties. The `last_winner` register is not instantiated.

## Test plan
- Fetch read, `MEM_LAT`=1, memory[0x0010]=0xDEADBEEF, `if_req` at cycle 0 -> `if_gnt` and `mem_en` at cycle 1 with `mem_addr`=0x0010 and `mem_we`=0; `if_valid` at cycle 3 with `if_rdata`=0xDEADBEEF; `busy` low at cycle 4.
- Store then load, `ls_we`=1, addr 0x0020, data 0x12345678, followed by a load of 0x0020 -> `mem_we`=1 only in the store's GRANT; `ls_valid` with `ls_rdata`=0; load returns 0x12345678.
- Tie, both ports requesting at cycle 0 and holding through two transactions:
  - Default build: `ls` granted first, then `if`.
  - `MEM_ARB_FAIR_EN` build: `if` first, then `ls`. Across 6 continuous ties, grants strictly alternate.
- Request during busy: `ls_req` rises in WAIT of an `if` transaction -> `ls_gnt` exactly 2 cycles after `if_valid`; no `mem_en` while busy except in GRANT.
- Reset mid-op: `rst_f` low during WAIT -> same cycle `busy`, `mem_en`, and `valid` are 0 and `rdata` is 0; no `valid` after release; a new `if_req` completes normally.
- `MEM_LAT`=3: fetch completes with `if_valid` at cycle 5; data is sampled only at the end of cycle 4.

Source files
------------

// File: rtl/mem_arb_if.sv
// Bus bundle for mem_arb: fetch port, load/store port and the memory side.
// The slave modport is the arbiter's view; master is the requester/memory view.
interface mem_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_valid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arb.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Define MEM_ARB_FAIR_EN for alternating tie-break; default is fixed ls priority.
module mem_arb #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input logic     clk,
    input logic     rst_f,
    mem_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_t;

    state_t            state, state_d;
    logic [2:0]        cnt, cnt_d;
    logic              win_ls, win_ls_d;
    logic              lat_we, lat_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              if_gnt_q, if_gnt_d;
    logic              ls_gnt_q, ls_gnt_d;
    logic              if_valid_q, if_valid_d;
    logic              ls_valid_q, ls_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              busy_q, busy_d;
    logic              tie_ls;
    logic              pick_ls;

`ifdef MEM_ARB_FAIR_EN
    logic last_ls;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)
            last_ls <= 1'b1;
        else if (state == GRANT)
            last_ls <= win_ls;
    end

    assign tie_ls = !last_ls;
`else
    assign tie_ls = 1'b1;
`endif

    assign pick_ls = bus.ls_req && (!bus.if_req || tie_ls);

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        win_ls_d    = win_ls;
        lat_we_d    = lat_we;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        ls_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;

        // Outputs are registered, so each state's outputs are computed one state early.
        case (state)
            IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    win_ls_d    = pick_ls;
                    lat_we_d    = pick_ls && bus.ls_we;
                    mem_addr_d  = pick_ls ? bus.ls_addr : bus.if_addr;
                    mem_wdata_d = pick_ls ? bus.ls_wdata : '0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_ls && bus.ls_we;
                    if_gnt_d    = !pick_ls;
                    ls_gnt_d    = pick_ls;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                cnt_d   = 3'(MEM_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_d = RESP;
                    if (win_ls) begin
                        ls_valid_d = 1'b1;
                        ls_rdata_d = lat_we ? '0 : bus.mem_rdata;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state       <= IDLE;
            cnt         <= '0;
            win_ls      <= 1'b1;
            lat_we      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            win_ls      <= win_ls_d;
            lat_we      <= lat_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_valid_q  <= if_valid_d;
            ls_valid_q  <= ls_valid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.if_gnt    = if_gnt_q;
    assign bus.ls_gnt    = ls_gnt_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.ls_valid  = ls_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: one instance at MEM_LAT=1, one at MEM_LAT=3.
// Memory models return junk except in the exact cycle read data is due.
module tb_mem_arb;
    logic clk = 1'b0;
    logic rst_f;
    int   errors = 0;
    int   checks = 0;
    int   viol   = 0;

`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam bit FIRST_LS = !FAIR;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_W(16), .DATA_W(32)) bus_a ();
    mem_arb_if #(.ADDR_W(16), .DATA_W(32)) bus_b ();

    mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) u_dut_a (.clk(clk), .rst_f(rst_f), .bus(bus_a));
    mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(3)) u_dut_b (.clk(clk), .rst_f(rst_f), .bus(bus_b));

    function automatic logic [31:0] memval(input logic [15:0] addr);
        return (addr == 16'h0010) ? 32'hDEAD_BEEF : {16'hC0DE, addr};
    endfunction

    // latency-1 memory with a single write slot
    logic        va, wv;
    logic [15:0] wa;
    logic [31:0] da, wd;
    initial begin va = 1'b0; wv = 1'b0; wa = '0; wd = '0; da = '0; end
    always @(posedge clk) begin
        va <= bus_a.mem_en && !bus_a.mem_we;
        da <= (wv && bus_a.mem_addr == wa) ? wd : memval(bus_a.mem_addr);
        if (bus_a.mem_en && bus_a.mem_we) begin
            wv <= 1'b1;
            wa <= bus_a.mem_addr;
            wd <= bus_a.mem_wdata;
        end
    end
    assign bus_a.mem_rdata = va ? da : JUNK;

    // latency-3 read-only memory
    logic [2:0]  vb;
    logic [31:0] db [3];
    initial begin vb = '0; db[0] = '0; db[1] = '0; db[2] = '0; end
    always @(posedge clk) begin
        vb    <= {vb[1:0], bus_b.mem_en && !bus_b.mem_we};
        db[0] <= memval(bus_b.mem_addr);
        db[1] <= db[0];
        db[2] <= db[1];
    end
    assign bus_b.mem_rdata = vb[2] ? db[2] : JUNK;

    always @(negedge clk) begin
        if ((bus_a.if_gnt && bus_a.ls_gnt) || (bus_a.if_valid && bus_a.ls_valid) ||
            (bus_a.mem_we && !bus_a.mem_en) || (bus_a.mem_en != (bus_a.if_gnt || bus_a.ls_gnt)))
            viol++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  nv;
        bit  exp_ls;
        bus_a.if_req = 0; bus_a.if_addr = '0; bus_a.ls_req = 0; bus_a.ls_we = 0;
        bus_a.ls_addr = '0; bus_a.ls_wdata = '0;
        bus_b.if_req = 0; bus_b.if_addr = '0; bus_b.ls_req = 0; bus_b.ls_we = 0;
        bus_b.ls_addr = '0; bus_b.ls_wdata = '0;
        rst_f = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", bus_a.busy, 0);
        check("rst mem_en", bus_a.mem_en, 0);
        check("rst if_rdata", bus_a.if_rdata, 0);
        check("rst mem_addr", bus_a.mem_addr, 0);
        check("rst gnt", {bus_a.if_gnt, bus_a.ls_gnt}, 0);
        rst_f = 1'b1;
        tick();

        // fetch on both latencies
        bus_a.if_req = 1; bus_a.if_addr = 16'h0010;
        bus_b.if_req = 1; bus_b.if_addr = 16'h0010;
        tick();
        check("fetch if_gnt", bus_a.if_gnt, 1);
        check("fetch mem_en", bus_a.mem_en, 1);
        check("fetch mem_addr", bus_a.mem_addr, 16'h0010);
        check("fetch mem_we", bus_a.mem_we, 0);
        check("lat3 if_gnt", bus_b.if_gnt, 1);
        tick();
        check("fetch early valid", bus_a.if_valid, 0);
        tick();
        check("fetch if_valid", bus_a.if_valid, 1);
        check("fetch if_rdata", bus_a.if_rdata, 32'hDEAD_BEEF);
        check("lat3 early valid", bus_b.if_valid, 0);
        bus_a.if_req = 0;
        tick();
        check("fetch busy done", bus_a.busy, 0);
        check("lat3 c4 valid", bus_b.if_valid, 0);
        tick();
        check("lat3 if_valid", bus_b.if_valid, 1);
        check("lat3 if_rdata", bus_b.if_rdata, 32'hDEAD_BEEF);
        bus_b.if_req = 0;
        tick();

        // store then load
        bus_a.ls_req = 1; bus_a.ls_we = 1; bus_a.ls_addr = 16'h0020; bus_a.ls_wdata = 32'h1234_5678;
        tick();
        check("store ls_gnt", bus_a.ls_gnt, 1);
        check("store mem_we", bus_a.mem_we, 1);
        check("store mem_wdata", bus_a.mem_wdata, 32'h1234_5678);
        tick();
        check("store we wait", bus_a.mem_we, 0);
        tick();
        check("store ls_valid", bus_a.ls_valid, 1);
        check("store ls_rdata", bus_a.ls_rdata, 0);
        bus_a.ls_we = 0;
        tick();
        tick();
        check("load ls_gnt", bus_a.ls_gnt, 1);
        check("load mem_we", bus_a.mem_we, 0);
        check("load mem_addr", bus_a.mem_addr, 16'h0020);
        tick();
        tick();
        check("load ls_valid", bus_a.ls_valid, 1);
        check("load ls_rdata", bus_a.ls_rdata, 32'h1234_5678);
        check("if_rdata hold", bus_a.if_rdata, 32'hDEAD_BEEF);
        bus_a.ls_req = 0;
        tick();

        // reset in WAIT
        bus_a.if_req = 1; bus_a.if_addr = 16'h0010;
        tick();
        tick();
        check("midrst busy before", bus_a.busy, 1);
        rst_f = 1'b0;
        #1;
        check("midrst busy", bus_a.busy, 0);
        check("midrst mem_en", bus_a.mem_en, 0);
        check("midrst valid", {bus_a.if_valid, bus_a.ls_valid}, 0);
        check("midrst if_rdata", bus_a.if_rdata, 0);
        check("midrst ls_rdata", bus_a.ls_rdata, 0);
        bus_a.if_req = 0;
        tick();
        rst_f = 1'b1;
        nv = 0;
        repeat (5) begin
            tick();
            if (bus_a.if_valid || bus_a.ls_valid) nv++;
        end
        check("midrst no valid", nv, 0);
        bus_a.if_req = 1; bus_a.if_addr = 16'h0044;
        tick();
        check("postrst if_gnt", bus_a.if_gnt, 1);
        tick();
        tick();
        check("postrst if_valid", bus_a.if_valid, 1);
        check("postrst if_rdata", bus_a.if_rdata, 32'hC0DE_0044);
        bus_a.if_req = 0;
        tick();

        // tie after a fresh reset: winner drops, then the other
        rst_f = 1'b0;
        tick();
        rst_f = 1'b1;
        tick();
        bus_a.if_req = 1; bus_a.if_addr = 16'h0010;
        bus_a.ls_req = 1; bus_a.ls_we = 0; bus_a.ls_addr = 16'h0030;
        tick();
        check("tie1 if_gnt", bus_a.if_gnt, !FIRST_LS);
        check("tie1 ls_gnt", bus_a.ls_gnt, FIRST_LS);
        tick();
        tick();
        if (FIRST_LS) bus_a.ls_req = 0; else bus_a.if_req = 0;
        tick();
        tick();
        check("tie2 if_gnt", bus_a.if_gnt, FIRST_LS);
        check("tie2 ls_gnt", bus_a.ls_gnt, !FIRST_LS);
        tick();
        tick();
        check("tie2 valid", {bus_a.if_valid, bus_a.ls_valid}, FIRST_LS ? 2'b10 : 2'b01);
        bus_a.if_req = 1; bus_a.ls_req = 1;
        tick();

        // six continuous ties
        for (int k = 0; k < 6; k++) begin
            exp_ls = FAIR ? (k % 2 == 1) : 1'b1;
            tick();
            check("tieN if_gnt", bus_a.if_gnt, !exp_ls);
            check("tieN ls_gnt", bus_a.ls_gnt, exp_ls);
            tick();
            tick();
            check("tieN if_valid", bus_a.if_valid, !exp_ls);
            check("tieN ls_valid", bus_a.ls_valid, exp_ls);
            check("tieN rdata", exp_ls ? bus_a.ls_rdata : bus_a.if_rdata,
                  exp_ls ? 32'hC0DE_0030 : 32'hDEAD_BEEF);
            if (k == 5) begin bus_a.if_req = 0; bus_a.ls_req = 0; end
            tick();
        end
        check("tie idle busy", bus_a.busy, 0);

        // ls request arriving while an if transaction is in WAIT
        bus_a.if_req = 1; bus_a.if_addr = 16'h0040;
        tick();
        check("busyreq if_gnt", bus_a.if_gnt, 1);
        tick();
        bus_a.ls_req = 1; bus_a.ls_we = 0; bus_a.ls_addr = 16'h0050;
        tick();
        check("busyreq if_valid", bus_a.if_valid, 1);
        check("busyreq ls_gnt early", bus_a.ls_gnt, 0);
        bus_a.if_req = 0;
        tick();
        check("busyreq idle en", {bus_a.ls_gnt, bus_a.mem_en, bus_a.busy}, 0);
        tick();
        check("busyreq ls_gnt", bus_a.ls_gnt, 1);
        check("busyreq mem_addr", bus_a.mem_addr, 16'h0050);
        tick();
        tick();
        check("busyreq ls_valid", bus_a.ls_valid, 1);
        check("busyreq ls_rdata", bus_a.ls_rdata, 32'hC0DE_0050);
        bus_a.ls_req = 0;
        tick();

        check("invariants", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
